// File: rtl/skinny_dom_pkg.sv
// Shared constants and linear helpers for the DOM-masked SKINNY-128 super-box.
package skinny_dom_pkg;

  localparam int SHARES_DEFAULT = 2;
  localparam int LAT            = 5;

  function automatic int rw_bits(input int shares);
    return 16 * shares * (shares - 1);
  endfunction

  // Index of the unordered share pair {a,b} (a != b) within one gate's random slice.
  function automatic int pair_index(input int shares, input int a, input int b);
    int lo;
    int hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return lo * shares - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // MixColumns on one 32-bit column share, a3..a0 = bytes [31:24]..[7:0].
  function automatic logic [31:0] mc_col(input logic [31:0] a);
    return {a[7:0] ^ a[31:24] ^ a[15:8], a[31:24], a[23:16] ^ a[15:8], a[31:24] ^ a[15:8]};
  endfunction

  // Bit permutation applied between the S-box nonlinear layers.
  function automatic logic [7:0] sbox_perm(input logic [7:0] y);
    return {y[2], y[1], y[7], y[6], y[4], y[0], y[3], y[5]};
  endfunction

  // Final S-box bit swap (bits 1 and 2) replacing the fourth permutation.
  function automatic logic [7:0] sbox_swap(input logic [7:0] y);
    return {y[7:3], y[1], y[2], y[0]};
  endfunction

endpackage

// File: rtl/skinny_sbox8_domd.sv
// Four-stage DOM-indep masked SKINNY-128 S-box; works on the complemented state so
// each layer is two AND-XOR gates, with the complement applied to share 0 only.
module skinny_sbox8_domd
  import skinny_dom_pkg::*;
#(
  parameter int SHARES = SHARES_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [8*SHARES-1:0]             x,
  input  logic [4*SHARES*(SHARES-1)-1:0]  r,
  output logic [8*SHARES-1:0]             y
);

  localparam int P  = SHARES * (SHARES - 1) / 2;
  localparam int RL = 2 * P;

  for (genvar gi = 0; gi < 4; gi++) begin : g_layer
    logic [7:0]        lin  [SHARES];
    logic [7:0]        st_d [SHARES];
    logic [7:0]        st_q [SHARES];
    logic [SHARES-1:0] cr_d [2][SHARES];
    logic [SHARES-1:0] cr_q [2][SHARES];
    logic [7:0]        cmp  [SHARES];
    logic [RL-1:0]     rl;

    assign rl = r[RL*gi +: RL];

    if (gi == 0) begin : g_in
      always_comb begin
        for (int s = 0; s < SHARES; s++)
          lin[s] = x[8*s +: 8] ^ ((s == 0) ? 8'hFF : 8'h00);
      end
    end else begin : g_mid
      always_comb begin
        for (int s = 0; s < SHARES; s++)
          lin[s] = sbox_perm(g_layer[gi-1].cmp[s]);
      end
    end

    // Inner-domain products fold into the state register; cross-domain terms are
    // blinded with the pair's fresh bit and kept in separate registers until compression.
    always_comb begin
      for (int s = 0; s < SHARES; s++) begin
        st_d[s]    = lin[s];
        st_d[s][0] = lin[s][0] ^ (lin[s][2] & lin[s][3]);
        st_d[s][4] = lin[s][4] ^ (lin[s][6] & lin[s][7]);
        for (int g = 0; g < 2; g++) begin
          cr_d[g][s] = '0;
          for (int t = 0; t < SHARES; t++) begin
            if (t != s)
              cr_d[g][s][t] = (lin[s][4*g+2] & lin[t][4*g+3]) ^ rl[g*P + pair_index(SHARES, s, t)];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SHARES; s++) begin
          st_q[s]    <= '0;
          cr_q[0][s] <= '0;
          cr_q[1][s] <= '0;
        end
      end else if (en) begin
        for (int s = 0; s < SHARES; s++) begin
          st_q[s]    <= st_d[s];
          cr_q[0][s] <= cr_d[0][s];
          cr_q[1][s] <= cr_d[1][s];
        end
      end
    end

    always_comb begin
      for (int s = 0; s < SHARES; s++) begin
        cmp[s]    = st_q[s];
        cmp[s][0] = st_q[s][0] ^ (^cr_q[0][s]);
        cmp[s][4] = st_q[s][4] ^ (^cr_q[1][s]);
      end
    end
  end

  always_comb begin
    y = '0;
    for (int s = 0; s < SHARES; s++)
      y[8*s +: 8] = sbox_swap(g_layer[3].cmp[s]) ^ ((s == 0) ? 8'hFF : 8'h00);
  end

endmodule

// File: rtl/skinny_superbox32_domd_pipelined.sv
// Masked SKINNY-128 column super-box: SB (4 DOM stages), AK on the top half, MC,
// then a share-wise output register. One beat per cycle with a global stall enable.
module skinny_superbox32_domd_pipelined
  import skinny_dom_pkg::*;
#(
  parameter  int SHARES = SHARES_DEFAULT,
  parameter  int TAGW   = 4,
  localparam int RW     = rw_bits(SHARES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*SHARES-1:0]   si,
  input  logic [16*SHARES-1:0]   k,
  input  logic [RW-1:0]          r,
  input  logic [TAGW-1:0]        in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*SHARES-1:0]   so,
  output logic [TAGW-1:0]        out_tag,
  output logic                   busy
);

  logic                 en;
  logic [3:0]           vld_q;
  logic [16*SHARES-1:0] key_q [4];
  logic [TAGW-1:0]      tag_q [4];
  logic [32*SHARES-1:0] sb;
  logic [32*SHARES-1:0] mc;

  assign in_ready = !(out_valid && !out_ready);
  assign en       = in_ready;
  assign busy     = (|vld_q) | out_valid;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    logic [8*SHARES-1:0] bx;
    logic [8*SHARES-1:0] by;

    for (genvar gs = 0; gs < SHARES; gs++) begin : g_sh
      assign bx[8*gs +: 8]          = si[32*gs + 8*gi +: 8];
      assign sb[32*gs + 8*gi +: 8]  = by[8*gs +: 8];
    end

    skinny_sbox8_domd #(.SHARES(SHARES)) u_sbox (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .x     (bx),
      .r     (r[RW/4*gi +: RW/4]),
      .y     (by)
    );
  end

  // AK and MC are linear, so they run share by share with the key share of the same index.
  always_comb begin
    mc = '0;
    for (int s = 0; s < SHARES; s++)
      mc[32*s +: 32] = mc_col(sb[32*s +: 32] ^ {key_q[3][16*s +: 16], 16'h0000});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      out_valid <= 1'b0;
      so        <= '0;
      out_tag   <= '0;
      for (int i = 0; i < 4; i++) begin
        key_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (en) begin
      vld_q    <= {vld_q[2:0], in_valid};
      key_q[0] <= k;
      tag_q[0] <= in_tag;
      for (int i = 1; i < 4; i++) begin
        key_q[i] <= key_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      out_valid <= vld_q[3];
      so        <= mc;
      out_tag   <= tag_q[3];
    end
  end

endmodule

// File: tb/tb_skinny_superbox32_domd_pipelined.sv
// Self-checking bench for the masked SKINNY super-box (SHARES=2 and SHARES=3 instances).
module tb_skinny_superbox32_domd_pipelined;

  localparam int TAGW = 4;
  localparam int RW2  = 32;
  localparam int RW3  = 96;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0]     si, so;
  logic [31:0]     k;
  logic [RW2-1:0]  r;
  logic [TAGW-1:0] in_tag, out_tag;

  logic            c3_in_valid, c3_in_ready, c3_out_valid, c3_out_ready, c3_busy;
  logic [95:0]     c3_si, c3_so;
  logic [47:0]     c3_k;
  logic [RW3-1:0]  c3_r;
  logic [TAGW-1:0] c3_in_tag, c3_out_tag;

  int n_cmp;
  int n_err;

  logic [31:0]     exp_q[$];
  logic [TAGW-1:0] etag_q[$];

  skinny_superbox32_domd_pipelined #(.SHARES(2), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .si(si), .k(k), .r(r), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .so(so), .out_tag(out_tag), .busy(busy)
  );

  skinny_superbox32_domd_pipelined #(.SHARES(3), .TAGW(TAGW)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(c3_in_valid), .in_ready(c3_in_ready),
    .si(c3_si), .k(c3_k), .r(c3_r), .in_tag(c3_in_tag), .out_valid(c3_out_valid),
    .out_ready(c3_out_ready), .so(c3_so), .out_tag(c3_out_tag), .busy(c3_busy)
  );

  // Reference S-box straight from the SKINNY-128 description (NOR form, plain byte math).
  function automatic logic [7:0] sbox_ref(input logic [7:0] v);
    logic [7:0] x;
    x = v;
    for (int it = 0; it < 4; it++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (it < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
      else        x = {x[7:3], x[1], x[2], x[0]};
    end
    return x;
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] v, input logic [15:0] kk);
    logic [7:0] a3, a2, a1, a0;
    a3 = sbox_ref(v[31:24]) ^ kk[15:8];
    a2 = sbox_ref(v[23:16]) ^ kk[7:0];
    a1 = sbox_ref(v[15:8]);
    a0 = sbox_ref(v[7:0]);
    return {a0 ^ a3 ^ a1, a3, a2 ^ a1, a3 ^ a1};
  endfunction

  task automatic set_beat(input logic [31:0] v, input logic [15:0] kk,
                          input logic [TAGW-1:0] tg, input logic split);
    logic [31:0] m;
    logic [15:0] mk;
    m  = split ? $urandom : 32'h0;
    mk = split ? 16'($urandom) : 16'h0;
    si = {m, v ^ m};
    k  = {mk, kk ^ mk};
    in_tag = tg;
    in_valid = 1'b1;
    r = $urandom;
  endtask

  task automatic set_idle;
    in_valid = 1'b0;
    si = {$urandom, $urandom};
    k = $urandom;
    r = $urandom;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    out_ready = 1'b1; c3_out_ready = 1'b1; c3_in_valid = 1'b0;
    c3_si = '0; c3_k = '0; c3_r = '0; c3_in_tag = '0; in_tag = '0;
    set_idle;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (so !== 64'h0) begin n_err++; $display("FAIL reset_so: got %h expected 0", so); end
    n_cmp++; if (out_tag !== 4'h0) begin n_err++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    $display("reset: done");
  endtask

  task automatic run_single(input string name, input logic [31:0] v, input logic [15:0] kk,
                            input logic [TAGW-1:0] tg, input logic split, input logic [31:0] expv);
    int lat;
    out_ready = 1'b1;
    @(negedge clk); set_beat(v, kk, tg, split);
    @(negedge clk); set_idle;
    lat = 1;
    while (!out_valid && lat < 12) begin @(negedge clk); lat++; end
    n_cmp++; if (lat != 5) begin n_err++; $display("FAIL %s_latency: got %0d expected 5", name, lat); end
    n_cmp++; if ((so[31:0] ^ so[63:32]) !== expv) begin n_err++; $display("FAIL %s_data: got %h expected %h", name, so[31:0] ^ so[63:32], expv); end
    n_cmp++; if (out_tag !== tg) begin n_err++; $display("FAIL %s_tag: got %h expected %h", name, out_tag, tg); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_single_pulse: got %b expected 0", name, out_valid); end
    $display("%s: in=%h key=%h tag=%h out=%h", name, v, kk, tg, so[31:0] ^ so[63:32]);
  endtask

  task automatic test_known_answers;
    run_single("zero_key", 32'h0, 16'h0000, 4'h5, 1'b0, 32'h65650000);
    run_single("ones_key", 32'h0, 16'hFFFF, 4'hA, 1'b1, 32'h9A9AFFFF);
  endtask

  task automatic test_random_singles;
    logic [31:0] v;
    logic [15:0] kk;
    for (int i = 0; i < 4; i++) begin
      v = $urandom; kk = 16'($urandom);
      run_single("random_single", v, kk, 4'(i + 3), 1'b1, ref_col(v, kk));
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    logic [15:0] kk;
    logic [31:0] e;
    logic [TAGW-1:0] et;
    exp_q.delete(); etag_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== (c >= 5 && c <= 12)) begin
        n_err++; $display("FAIL b2b_valid_c%0d: got %b expected %b", c, out_valid, (c >= 5 && c <= 12));
      end
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front(); et = etag_q.pop_front();
        n_cmp++; if ((so[31:0] ^ so[63:32]) !== e || out_tag !== et) begin
          n_err++; $display("FAIL b2b_data_c%0d: got %h/%h expected %h/%h", c, so[31:0] ^ so[63:32], out_tag, e, et);
        end
        $display("b2b: cycle %0d out=%h tag=%h", c, so[31:0] ^ so[63:32], out_tag);
      end
      if (c < 8) begin
        v = $urandom; kk = 16'($urandom);
        set_beat(v, kk, 4'(c), 1'b1);
        exp_q.push_back(ref_col(v, kk)); etag_q.push_back(4'(c));
      end else set_idle;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_lost: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_stall;
    int sent, got;
    logic held;
    logic [63:0] hso;
    logic [TAGW-1:0] htag;
    logic [31:0] v, e;
    logic [15:0] kk;
    logic [TAGW-1:0] et;
    exp_q.delete(); etag_q.delete();
    sent = 0; got = 0; held = 1'b0; hso = '0; htag = '0;
    for (int c = 0; c < 600 && got < 40; c++) begin
      @(negedge clk);
      if (held) begin
        n_cmp++; if (so !== hso || out_tag !== htag || out_valid !== 1'b1) begin
          n_err++; $display("FAIL stall_hold_c%0d: got %h/%h expected %h/%h", c, so, out_tag, hso, htag);
        end
      end
      if (c >= 10 && c < 13) out_ready = 1'b0;
      else if (c < 10)       out_ready = 1'b1;
      else                   out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 40 && (c < 10 || $urandom_range(0, 4) != 0)) begin
        v = $urandom; kk = 16'($urandom);
        set_beat(v, kk, 4'(sent), 1'b1);
      end else set_idle;
      #1;
      if (out_valid && !out_ready) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_c%0d: got %b expected 0", c, in_ready); end
      end
      held = out_valid && !out_ready; hso = so; htag = out_tag;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stall_extra_beat: got %h expected none", so[31:0] ^ so[63:32]);
        end else begin
          e = exp_q.pop_front(); et = etag_q.pop_front();
          if ((so[31:0] ^ so[63:32]) !== e || out_tag !== et) begin
            n_err++; $display("FAIL stall_data: got %h/%h expected %h/%h", so[31:0] ^ so[63:32], out_tag, e, et);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_col(v, kk)); etag_q.push_back(4'(sent)); sent++;
      end
    end
    set_idle; out_ready = 1'b1;
    n_cmp++; if (got != 40 || exp_q.size() != 0) begin n_err++; $display("FAIL stall_count: got %0d expected 40", got); end
    $display("stall: sent=%0d received=%0d", sent, got);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    logic seen;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); set_beat($urandom, 16'($urandom), 4'(i), 1'b1);
    end
    @(negedge clk); set_idle;
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got %b/%b expected 1/1", busy, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (so !== 64'h0 || out_tag !== 4'h0) begin n_err++; $display("FAIL midrst_so: got %h expected 0", so); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_after: got %b expected 0", seen); end
    $display("reset_midflight: done");
  endtask

  task automatic test_shares3;
    int sent, got;
    logic [31:0] v, m1, m2, e;
    logic [15:0] kk, n1, n2;
    logic [TAGW-1:0] et;
    exp_q.delete(); etag_q.delete();
    sent = 0; got = 0;
    c3_out_ready = 1'b1;
    for (int c = 0; c < 3000 && got < 1000; c++) begin
      @(negedge clk);
      if (c3_out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL s3_extra_beat: got %h expected none", c3_so[31:0] ^ c3_so[63:32] ^ c3_so[95:64]);
        end else begin
          e = exp_q.pop_front(); et = etag_q.pop_front();
          if ((c3_so[31:0] ^ c3_so[63:32] ^ c3_so[95:64]) !== e || c3_out_tag !== et) begin
            n_err++; $display("FAIL s3_data: got %h/%h expected %h/%h",
                              c3_so[31:0] ^ c3_so[63:32] ^ c3_so[95:64], c3_out_tag, e, et);
          end
        end
        got++;
      end
      v = $urandom; kk = 16'($urandom);
      m1 = $urandom; m2 = $urandom; n1 = 16'($urandom); n2 = 16'($urandom);
      c3_si = {m2, m1, v ^ m1 ^ m2};
      c3_k  = {n2, n1, kk ^ n1 ^ n2};
      c3_r  = {$urandom, $urandom, $urandom};
      c3_in_tag = 4'($urandom);
      c3_in_valid = (sent < 1000) && ($urandom_range(0, 4) != 0);
      if (c3_in_valid) begin
        exp_q.push_back(ref_col(v, kk)); etag_q.push_back(c3_in_tag); sent++;
      end
    end
    c3_in_valid = 1'b0;
    n_cmp++; if (got != 1000) begin n_err++; $display("FAIL s3_count: got %0d expected 1000", got); end
    $display("shares3: sent=%0d received=%0d", sent, got);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_known_answers;
    test_random_singles;
    test_back_to_back;
    test_stall;
    test_reset_midflight;
    test_shares3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/skinny_superbox32_domd_pipelined.md
SKINNY_SUPERBOX32_DOMD_PIPELINED -- requirements
Module: skinny_superbox32_domd_pipelined

Interface
REQ-001 Parameter SHARES, default 2: number of Boolean shares (DOM order SHARES-1); legal values 2..4.
REQ-002 Parameter TAGW, default 4: width of the sideband tag carried with each beat.
REQ-003 Derived RW = 16*SHARES*(SHARES-1): random bits per cycle (32 when SHARES=2).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  input beat offered.
REQ-007 in_ready  out  1  input beat accepted when in_valid&in_ready.
REQ-008 si  in  32*SHARES  column state shares; share j is si[32j+31:32j].
REQ-009 k  in  16*SHARES  round-key shares; share j is k[16j+15:16j].
REQ-010 r  in  RW  fresh randomness for DOM resharing.
REQ-011 in_tag  in  TAGW  sideband tag, unmasked.
REQ-012 out_valid  out  1  output beat present.
REQ-013 out_ready  in  1  downstream accepts beat.
REQ-014 so  out  32*SHARES  output shares, same layout as si.
REQ-015 out_tag  out  TAGW  tag of the output beat.
REQ-016 busy  out  1  high while any beat is in flight.

Function
REQ-017 XOR of so shares SHALL equal MC(AK(SB(XOR of si shares), XOR of k shares)).
REQ-018 SB: SKINNY-128 8-bit S-box applied to each byte; AK: key XORed into bits [31:16] only; MC per share with a3..a0 = bytes [31:24]..[7:0]: out[23:16]=a3, out[15:8]=a2^a1, out[7:0]=a3^a1, out[31:24]=a0^a3^a1.
REQ-019 Each S-box SHALL use DOM-indep multiplication for its 8 nonlinear gates (2 per layer), one register stage per layer: 4 stages.
REQ-020 Key shares and tag SHALL be delayed alongside data, so AK uses the key captured with that beat.
REQ-021 AK+MC SHALL be combinational from stage 4 into a share-wise output register; latency = 5 cycles from acceptance to out_valid with no stall.
REQ-022 Throughput one beat per cycle; in_ready = !(out_valid & !out_ready).
REQ-023 Global enable en = in_ready: all stages, valid bits and output register advance only when en=1; on stall all hold exactly.
REQ-024 r SHALL be consumed only when en=1; r[RW/4*i +: RW/4] feeds S-box i; within it, layer L uses slice [RW/16*L +: RW/16].
REQ-025 A bubble (en=1, in_valid=0) SHALL propagate as valid=0; bubble data registers are don't-care but SHALL not recombine shares.
REQ-026 busy = OR of the 4 stage valid bits and out_valid.
REQ-027 Output stays stable (so, out_tag, out_valid) while out_valid & !out_ready.
REQ-028 No register SHALL combine two shares of the same value except through DOM gates with their fresh random bit registered.

Reset
REQ-029 On rst_n low, immediately: out_valid=0, all stage valid bits=0, busy=0, so=0, out_tag=0; in_ready=1 one cycle after release.
REQ-030 Reset mid-operation SHALL discard in-flight beats; no partial beat emerges after release.

Structure
REQ-031 Package skinny_dom_pkg SHALL hold SHARES default, LAT=5, RW function of SHARES, and the MC byte function.
REQ-032 One sub-module skinny_sbox8_domd (SHARES, en, 4 stages); superbox instantiates four.

Verification
REQ-033 SHARES=2, si=0 all shares, k=0 -> so recombines to 0x65650000 at cycle 5, out_tag echoed.
REQ-034 si=0, k recombines to 0xFFFF, random share split -> recombined 0x9A9AFFFF.
REQ-035 Back-to-back 8 beats, out_ready=1 -> 8 consecutive out_valid, cycles 5..12, order and tags preserved.
REQ-036 out_ready=0 for 3 cycles with pipeline full -> in_ready=0, so held, no beat lost or duplicated; r ignored during stall.
REQ-037 rst_n asserted with 3 beats in flight -> out_valid=0 and busy=0 immediately, no output after release.
REQ-038 SHARES=3, 1000 random inputs/keys/r vs golden model -> recombined outputs match; any single share alone statistically independent of input.
